// File: rtl/max_n_fp_seq_if.sv
// Sample/result bundle for the sequential FP32 max/argmax reducer.
// FP_NAN_CHECK_EN adds the o_nan result flag to the bundle.
interface max_n_fp_seq_if #(
  parameter int IDX_W = 2
);
  logic             i_valid;
  logic [31:0]      i_data;
  logic             i_clear;
  logic             o_busy;
  logic             o_valid;
  logic [31:0]      o_data;
  logic [IDX_W-1:0] o_idx;
`ifdef FP_NAN_CHECK_EN
  logic             o_nan;
`endif

  // Upstream side: Q-table read port feeding samples.
  modport master (
    output i_valid, i_data, i_clear,
    input  o_busy, o_valid, o_data, o_idx
`ifdef FP_NAN_CHECK_EN
    , input o_nan
`endif
  );

  // Reducer side.
  modport slave (
    input  i_valid, i_data, i_clear,
    output o_busy, o_valid, o_data, o_idx
`ifdef FP_NAN_CHECK_EN
    , output o_nan
`endif
  );
endinterface

// File: rtl/max_n_fp_seq.sv
// Sequential FP32 max/argmax reducer for action selection.
// Accepts NUM_ACTIONS samples (one per i_valid cycle, gaps allowed) and
// reports the largest value and its arrival index one cycle after the last
// sample. Comparison is done directly on sign/magnitude, no adder.
// Optional feature macro: FP_NAN_CHECK_EN -- NaN samples are never selected
// and raise a per-group sticky flag reported on o_nan.
module max_n_fp_seq #(
  parameter int NUM_ACTIONS = 4,
  parameter int IDX_W       = 2
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  max_n_fp_seq_if.slave      bus
);

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ACTIONS - 1);
  localparam logic [31:0]      QNAN     = 32'h7FC0_0000;

  // a strictly greater than b; +0 and -0 compare equal.
  function automatic logic fp_gt(input logic [31:0] a, input logic [31:0] b);
    logic both_zero;
    both_zero = (a[30:0] == 31'd0) && (b[30:0] == 31'd0);
    if (a[31] != b[31]) return !a[31] && !both_zero;
    else if (!a[31])    return a[30:0] > b[30:0];
    else                return a[30:0] < b[30:0];
  endfunction

  state_t           state, state_nx;
  logic [IDX_W-1:0] cnt, cnt_nx;
  logic [31:0]      best, best_nx;
  logic [IDX_W-1:0] best_idx, best_idx_nx;
  logic             done;
  logic             take;

  logic             valid_q;
  logic [31:0]      data_q;
  logic [IDX_W-1:0] idx_q;

`ifdef FP_NAN_CHECK_EN
  logic have, have_nx;       // best holds a non-NaN sample
  logic nan_seen, nan_nx;    // sticky: some sample of this group was NaN
  logic smp_nan;
  logic nan_q;
  assign smp_nan = (&bus.i_data[30:23]) && (|bus.i_data[22:0]);
`endif

  // Next-state and datapath selection for the group accumulator.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one
    // unassigned, which would otherwise infer a latch.
    state_nx    = state;
    cnt_nx      = cnt;
    best_nx     = best;
    best_idx_nx = best_idx;
    done        = 1'b0;
`ifdef FP_NAN_CHECK_EN
    have_nx     = have;
    nan_nx      = nan_seen;
    take        = !smp_nan && (!have || fp_gt(bus.i_data, best));
`else
    take        = fp_gt(bus.i_data, best);
`endif

    if (bus.i_clear) begin
      // Clear beats a coincident sample: the sample is dropped.
      state_nx = IDLE;
      cnt_nx   = '0;
    end else if (bus.i_valid) begin
      unique case (state)
        IDLE: begin
          best_nx     = bus.i_data;
          best_idx_nx = '0;
          cnt_nx      = IDX_W'(1);
          state_nx    = ACCUM;
`ifdef FP_NAN_CHECK_EN
          have_nx     = !smp_nan;
          nan_nx      = smp_nan;
`endif
        end
        ACCUM: begin
          if (take) begin
            best_nx     = bus.i_data;
            best_idx_nx = cnt;
`ifdef FP_NAN_CHECK_EN
            have_nx     = 1'b1;
`endif
          end
`ifdef FP_NAN_CHECK_EN
          nan_nx = nan_seen | smp_nan;
`endif
          if (cnt == LAST_IDX) begin
            done     = 1'b1;
            cnt_nx   = '0;
            state_nx = IDLE;
          end else begin
            cnt_nx = cnt + IDX_W'(1);
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  // State register and running best/argmax.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    // NOTE: the small accumulator registers are reset too; a reset mid-group
    // must leave no stale best/index behind for the next group.
    if (!i_rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      best     <= '0;
      best_idx <= '0;
`ifdef FP_NAN_CHECK_EN
      have     <= 1'b0;
      nan_seen <= 1'b0;
`endif
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      best     <= best_nx;
      best_idx <= best_idx_nx;
`ifdef FP_NAN_CHECK_EN
      have     <= have_nx;
      nan_seen <= nan_nx;
`endif
    end
  end

  // Result registers: load on the edge accepting the last sample, then hold.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      idx_q   <= '0;
`ifdef FP_NAN_CHECK_EN
      nan_q   <= 1'b0;
`endif
    end else begin
      valid_q <= done;
      if (done) begin
`ifdef FP_NAN_CHECK_EN
        data_q <= have_nx ? best_nx : QNAN;
        idx_q  <= have_nx ? best_idx_nx : '0;
        nan_q  <= nan_nx;
`else
        data_q <= best_nx;
        idx_q  <= best_idx_nx;
`endif
      end
    end
  end

  assign bus.o_busy  = (state == ACCUM);
  assign bus.o_valid = valid_q;
  assign bus.o_data  = data_q;
  assign bus.o_idx   = idx_q;
`ifdef FP_NAN_CHECK_EN
  assign bus.o_nan   = nan_q;
`endif

endmodule

// File: tb/tb_max_n_fp_seq.sv
// Directed bench for max_n_fp_seq: expected results are queued when a group
// is issued and a negedge monitor compares each o_valid pulse against them.
module tb_max_n_fp_seq;

  localparam int IDX_W = 2;

  typedef struct {
    logic [31:0] data;
    logic [31:0] idx;
    logic        nan;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_vec = 0;
  int   n_err = 0;
  exp_t exp_q[$];

  max_n_fp_seq_if #(.IDX_W(IDX_W)) bus ();

  max_n_fp_seq #(.NUM_ACTIONS(4), .IDX_W(IDX_W)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: every o_valid pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n && bus.o_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_o_valid: got o_data %h, expected no result at %0t", bus.o_data, $time);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("o_data", bus.o_data, e.data);
        check("o_idx", 32'(bus.o_idx), e.idx);
`ifdef FP_NAN_CHECK_EN
        check("o_nan", 32'(bus.o_nan), 32'(e.nan));
`endif
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic sample(input logic [31:0] d);
    bus.i_valid = 1'b1;
    bus.i_data  = d;
    @(posedge clk);
    #1;
    bus.i_valid = 1'b0;
    bus.i_data  = '0;
  endtask

  task automatic expect_res(input logic [31:0] d, input logic [31:0] i, input logic n);
    exp_t e;
    e.data = d;
    e.idx  = i;
    e.nan  = n;
    exp_q.push_back(e);
  endtask

  // Four consecutive samples; optionally confirm the 1-cycle result latency.
  task automatic group(input logic [31:0] s0, input logic [31:0] s1,
                       input logic [31:0] s2, input logic [31:0] s3,
                       input bit lat_check);
    sample(s0);
    sample(s1);
    sample(s2);
    sample(s3);
    if (lat_check) begin
      @(negedge clk);
      check("latency_o_valid", 32'(bus.o_valid), 32'd1);
      @(posedge clk);
      #1;
      check("o_valid_one_cycle", 32'(bus.o_valid), 32'd0);
    end
  endtask

  initial begin
    rst_n       = 1'b0;
    bus.i_valid = 1'b0;
    bus.i_data  = '0;
    bus.i_clear = 1'b0;
    idle(2);
    check("rst_o_busy", 32'(bus.o_busy), 32'd0);
    check("rst_o_valid", 32'(bus.o_valid), 32'd0);
    check("rst_o_data", bus.o_data, 32'h0);
    check("rst_o_idx", 32'(bus.o_idx), 32'd0);
`ifdef FP_NAN_CHECK_EN
    check("rst_o_nan", 32'(bus.o_nan), 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Basic
    expect_res(32'h4000_0000, 1, 1'b0);
    group(32'h3F80_0000, 32'h4000_0000, 32'h3F00_0000, 32'hBF80_0000, 1'b1);
    // All negative
    expect_res(32'hBF00_0000, 1, 1'b0);
    group(32'hC040_0000, 32'hBF00_0000, 32'hBF80_0000, 32'hC040_0000, 1'b1);
    // Tie keeps lower index
    expect_res(32'h4000_0000, 0, 1'b0);
    group(32'h4000_0000, 32'h3F80_0000, 32'h4000_0000, 32'h3F00_0000, 1'b1);
    // -0 then +0 compare equal
    expect_res(32'h8000_0000, 0, 1'b0);
    group(32'h8000_0000, 32'h0000_0000, 32'hBF80_0000, 32'hC040_0000, 1'b1);

    // Gaps inside a group, then back-to-back groups
    expect_res(32'h4080_0000, 3, 1'b0);
    sample(32'h3F00_0000);
    idle(2);
    sample(32'h4040_0000);
    idle(1);
    sample(32'h4000_0000);
    idle(3);
    sample(32'h4080_0000);
    expect_res(32'h4110_0000, 2, 1'b0);
    group(32'h4100_0000, 32'hC100_0000, 32'h4110_0000, 32'h3F80_0000, 1'b0);
    expect_res(32'h3F80_0000, 0, 1'b0);
    group(32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 1'b0);
    idle(2);

    // Clear with a coincident sample
    sample(32'h3F80_0000);
    sample(32'h4000_0000);
    check("busy_mid_group", 32'(bus.o_busy), 32'd1);
    bus.i_clear = 1'b1;
    bus.i_valid = 1'b1;
    bus.i_data  = 32'h7F00_0000;
    @(posedge clk);
    #1;
    bus.i_clear = 1'b0;
    bus.i_valid = 1'b0;
    check("clear_busy", 32'(bus.o_busy), 32'd0);
    check("clear_o_data_held", bus.o_data, 32'h3F80_0000);
    idle(2);
    expect_res(32'h4000_0000, 2, 1'b0);
    group(32'hBF80_0000, 32'h3F80_0000, 32'h4000_0000, 32'h4000_0000, 1'b1);

    // Reset mid-group
    sample(32'h4100_0000);
    sample(32'h4200_0000);
    rst_n = 1'b0;
    #1;
    check("midrst_o_busy", 32'(bus.o_busy), 32'd0);
    check("midrst_o_valid", 32'(bus.o_valid), 32'd0);
    check("midrst_o_data", bus.o_data, 32'h0);
    check("midrst_o_idx", 32'(bus.o_idx), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    expect_res(32'h3F80_0000, 1, 1'b0);
    group(32'h3F00_0000, 32'h3F80_0000, 32'h3F00_0000, 32'h3E80_0000, 1'b1);

`ifdef FP_NAN_CHECK_EN
    expect_res(32'h3F80_0000, 1, 1'b1);
    group(32'h7FC0_0001, 32'h3F80_0000, 32'hBF80_0000, 32'h3F00_0000, 1'b1);
    expect_res(32'h7FC0_0000, 0, 1'b1);
    group(32'h7FC0_0001, 32'hFFC0_0000, 32'h7F80_0001, 32'h7FFF_FFFF, 1'b1);
    expect_res(32'h3F00_0000, 0, 1'b0);
    group(32'h3F00_0000, 32'hBF00_0000, 32'h3E00_0000, 32'h0000_0000, 1'b1);
`endif

    idle(4);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
